bcd_7seg_scan: RTL and testbench
================================

// Module: bcd_7seg_scan
// PURPOSE
//  Downstream consumer of the N-digit packed BCD counter bus. Time-multiplexes the
//  digits onto one common-anode 7-segment display (active-low anodes and segments).
//  Snapshots the BCD bus once per frame so a digit never changes mid-scan, blanks
//  leading zeros, and inserts anode dead time between digits to suppress ghosting.
// PARAMETERS
//  N          4      number of BCD digits; bcd_in width = 4*N
//  DIV        50000  clk cycles per digit slot (>= BLANK_CYC+1, >= 2)
//  BLANK_CYC  16     leading cycles of each slot with all anodes off (>= 0, < DIV)
//  LZB        1      1 = leading-zero blanking enabled, 0 = all digits always lit
// PORTS
//  clk         in   1     system clock, all logic on rising edge
//  rst         in   1     synchronous, active-high reset
//  bcd_in      in   4*N   packed BCD; digit i = bcd_in[4i+3:4i], digit 0 = LSD
//  dp_in       in   N     decimal point per digit, active-high
//  seg         out  8     {dp,g,f,e,d,c,b,a}, active-low, registered
//  an          out  N     anode enables, active-low, one-hot-low or all-high, registered
//  digit_idx   out  clog2(N)  index of the digit currently in its slot
//  frame_tick  out  1     one-cycle pulse on the cycle the snapshot is taken
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): cnt=0, digit_idx=0, snap=0, snap_dp=0,
//    an = all 1, seg = 8'hFF, frame_tick=0. rst dominates everything, mid-slot too.
//  - Slot counter cnt runs 0..DIV-1. At cnt==DIV-1: cnt<=0, digit_idx<=digit_idx+1,
//    wrapping N-1 -> 0.
//  - Snapshot: on the cycle cnt==DIV-1 && digit_idx==N-1, snap<=bcd_in, snap_dp<=dp_in,
//    frame_tick<=1 (else 0). First frame after reset shows snap=0 (displays "0").
//  - Phases per slot: BLANK while cnt<BLANK_CYC, SHOW otherwise. Dead time is
//    mandatory; a one-cycle overlap of two active anodes is a bug.
//  - Registered outputs, latency 1: on the edge after the internal state (cnt,
//    digit_idx) is sampled:
//      BLANK: an<=all 1, seg<=8'hFF.
//      SHOW : an<=~(1<<digit_idx), seg<=~{snap_dp[idx], decode(snap[idx])}.
//  - Decode: 0-9 standard patterns. 10-15 (invalid BCD): segment g only ("-"),
//    dp still honoured.
//  - Leading-zero blanking (LZB=1): digit i>0 is blank (seg[6:0] all 1) if snap
//    digits i..N-1 are all zero. Digit 0 is never blanked. dp of a blanked digit
//    is still driven from snap_dp. An invalid code (>9) is non-zero, so it stops
//    the blanking.
//  - The anode of a blanked digit is still asserted in SHOW (uniform duty cycle).
//  - bcd_in changes between snapshots have no effect on outputs.
//  - Frame period = N*DIV cycles. Per-digit on-time = DIV-BLANK_CYC cycles.
// STRUCTURE
//  - Shared package bcd_disp_pkg:
//    - SEG_* localparams for the 0-9 and dash patterns.
//    - function bcd_to_seg(input [3:0]) -> [6:0], active-high.
//    - Reused by any other display block.
//  - One sub-module, seg7_decoder:
//    - Combinational [3:0] -> [6:0] wrapper around bcd_to_seg.
//    - Instantiated once, on the muxed snap digit.
//  - Top holds the slot counter, digit index, snapshot registers, the LZB mask
//    (computed combinationally from snap) and the output registers.
// TESTING  (N=4, DIV=8, BLANK_CYC=2, LZB=1 unless stated)
//  1 Reset:
//    - rst=1 for 3 cycles mid-slot -> next cycle an=4'hF, seg=8'hFF, digit_idx=0.
//    - After release, the first SHOW (cycle 3 after release) shows an=4'hE, seg "0".
//  2 Snapshot:
//    - bcd_in=16'h1234 before the first frame_tick -> next frame shows
//      digit0 "4", digit1 "3", digit2 "2", digit3 "1".
//    - Changing bcd_in to 16'h9999 mid-frame -> the current frame is unchanged.
//  3 LZB:
//    - bcd_in=16'h0050 -> digits 3,2 seg[6:0]=7'h7F with their anodes still active.
//    - Digit1 shows "5"; digit0 shows "0".
//    - With LZB=0, all four digits are lit.
//    - bcd_in=16'h0000 -> only digit0 shows "0".
//  4 Timing:
//    - Check 2 all-off cycles then 6 single-active-anode cycles per slot.
//    - Never two anodes low in the same cycle.
//    - frame_tick period = 32 cycles.
//  5 Invalid/dp:
//    - bcd_in=16'h0A00, dp_in=4'b0010 -> digit2 shows "-", digit3 blank.
//    - Digit1 shows "0" with dp lit (seg[7]=0).
//  6 Scoreboard:
//    - Random bcd_in/dp_in over 200 frames, compared cycle-exact against a
//      reference model of the rules above.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared 7-segment display definitions: glyph patterns and BCD decode.
package bcd_disp_pkg;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Codes 10-15 are not BCD and render as a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed common-anode 7-segment driver for an N-digit packed BCD bus.
// The bus is snapshotted once per frame; each digit slot starts with anode
// dead time, and leading zeros can be blanked.
module bcd_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZB       = 1'b1,
  localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*N-1:0] bcd_in,
  input  logic [N-1:0]   dp_in,
  output logic [7:0]     seg,
  output logic [N-1:0]   an,
  output logic [IW-1:0]  digit_idx,
  output logic           frame_tick
);

  localparam int unsigned   CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [CW-1:0]  cnt;
  logic [4*N-1:0] snap;
  logic [N-1:0]   snap_dp;
  logic [3:0]     snap_digit [N];
  logic           slot_end;
  logic           frame_end;
  logic           in_blank;
  logic [3:0]     cur_bcd;
  logic [6:0]     cur_seg;
  logic [N-1:0]   lzb_mask;
  logic           zero_above;
  logic [N-1:0]   an_show;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit_idx == IDX_LAST);
  assign in_blank  = 32'(cnt) < BLANK_CYC;
  assign an_show   = ~(N'(1) << digit_idx);

  // Slot counter and digit index advance
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      cnt       <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame snapshot so a digit never changes mid-scan
  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      snap_dp    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        snap    <= bcd_in;
        snap_dp <= dp_in;
      end
    end
  end

  // Unpack snapshot into per-digit nibbles
  always_comb begin
    for (int i = 0; i < N; i++) begin
      snap_digit[i] = snap[4*i +: 4];
    end
  end

  assign cur_bcd = snap_digit[digit_idx];

  // Digit i>0 is blanked when it and every more significant digit are zero
  always_comb begin
    zero_above = 1'b1;
    lzb_mask   = '0;
    for (int i = N - 1; i >= 1; i--) begin
      zero_above  = zero_above & (snap_digit[i] == 4'd0);
      lzb_mask[i] = LZB & zero_above;
    end
  end

  seg7_decoder u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // Registered anode/segment drive; blanked digits keep anode on for even duty
  always_ff @(posedge clk) begin
    if (rst || in_blank) begin
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      an  <= an_show;
      seg <= ~{snap_dp[digit_idx], (lzb_mask[digit_idx] ? 7'h00 : cur_seg)};
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Randomized and directed bench for bcd_7seg_scan against a frame-level model.
module tb_bcd_7seg_scan;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [7:0]  seg, seg2;
  logic [3:0]  an, an2;
  logic [1:0]  digit_idx, idx2;
  logic        frame_tick, tick2;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int          m_k;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  logic        m_rst;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg, exp_seg2;
  logic [1:0]  exp_idx;
  logic        exp_tick;
  int          cyc = 0;
  int          last_tick = -1;

  // Per-frame capture
  logic [7:0] cap_seg [N];
  logic [7:0] cap_seg2 [N];
  int         on_cnt [N];
  int         blank_cnt;

  always #5 clk = ~clk;

  bcd_7seg_scan #(.N(N), .DIV(DIV), .BLANK_CYC(BLANK), .LZB(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  bcd_7seg_scan #(.N(N), .DIV(DIV), .BLANK_CYC(BLANK), .LZB(1'b0)) dut_nolzb (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .seg        (seg2),
    .an         (an2),
    .digit_idx  (idx2),
    .frame_tick (tick2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Character shown for a slot: blank if this and all higher digits are zero
  function automatic logic [7:0] model_seg(input logic [15:0] s, input logic [3:0] dp,
                                           input int slot, input bit lzb);
    logic [15:0] upper;
    logic [6:0]  g;
    upper = s >> (4 * slot);
    g     = glyph(upper[3:0]);
    if (lzb && slot > 0 && upper == 16'd0) g = 7'h00;
    return ~{dp[slot], g};
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    int pos, slot, off;
    m_rst = rst;
    if (rst) begin
      m_k      = 0;
      m_snap   = '0;
      m_dp     = '0;
      exp_an   = 4'hF;
      exp_seg  = 8'hFF;
      exp_seg2 = 8'hFF;
      exp_tick = 1'b0;
    end else begin
      pos  = m_k % FRAME;
      slot = pos / DIV;
      off  = pos % DIV;
      if (off < BLANK) begin
        exp_an   = 4'hF;
        exp_seg  = 8'hFF;
        exp_seg2 = 8'hFF;
      end else begin
        exp_an   = 4'(~(4'b0001 << slot));
        exp_seg  = model_seg(m_snap, m_dp, slot, 1'b1);
        exp_seg2 = model_seg(m_snap, m_dp, slot, 1'b0);
      end
      exp_tick = (pos == FRAME - 1);
      if (exp_tick) begin
        m_snap = bcd_in;
        m_dp   = dp_in;
      end
      m_k++;
    end
    exp_idx = 2'((m_k % FRAME) / DIV);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("an", an, exp_an);
    check("seg", seg, exp_seg);
    check("an_nolzb", an2, exp_an);
    check("seg_nolzb", seg2, exp_seg2);
    check("digit_idx", digit_idx, exp_idx);
    check("frame_tick", frame_tick, exp_tick);
    check("an_overlap", ($countones(~an) <= 1), 1);
    if (m_rst) begin
      last_tick = -1;
    end else if (frame_tick) begin
      if (last_tick >= 0) check("tick_period", cyc - last_tick, FRAME);
      last_tick = cyc;
    end
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (frame_tick) found = 1'b1;
    end
    if (!found) check("tick_timeout", 0, 1);
  endtask

  // Capture one full frame after a tick; optionally change bcd_in mid-frame
  task automatic capture_frame(input bit mid_change, input logic [15:0] mid_val);
    blank_cnt = 0;
    for (int d = 0; d < N; d++) begin
      cap_seg[d]  = 8'h00;
      cap_seg2[d] = 8'h00;
      on_cnt[d]   = 0;
    end
    for (int c = 0; c < FRAME; c++) begin
      if (mid_change && c == FRAME / 2) bcd_in = mid_val;
      step();
      if (an == 4'hF) begin
        blank_cnt++;
      end else begin
        for (int d = 0; d < N; d++) begin
          if (!an[d]) begin
            cap_seg[d] = seg;
            on_cnt[d]++;
          end
          if (!an2[d]) cap_seg2[d] = seg2;
        end
      end
    end
    check("blank_cycles", blank_cnt, N * BLANK);
    for (int d = 0; d < N; d++) check("on_cycles", on_cnt[d], DIV - BLANK);
  endtask

  task automatic show_frame(input logic [15:0] b, input logic [3:0] dp);
    bcd_in = b;
    dp_in  = dp;
    wait_tick();
    capture_frame(1'b0, 16'h0);
  endtask

  initial begin
    rst    = 1'b1;
    bcd_in = 16'h0;
    dp_in  = 4'h0;
    repeat (3) step();
    rst = 1'b0;
    repeat (13) step();

    // Reset mid-slot
    rst = 1'b1;
    repeat (3) step();
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 8'hFF);
    check("rst_idx", digit_idx, 0);
    rst = 1'b0;
    repeat (3) step();
    check("first_show_an", an, 4'hE);
    check("first_show_seg", seg, 8'hC0);

    // Snapshot of 1234; a mid-frame change must not disturb the frame
    bcd_in = 16'h1234;
    wait_tick();
    capture_frame(1'b1, 16'h9999);
    check("snap_d0", cap_seg[0], 8'h99);
    check("snap_d1", cap_seg[1], 8'hB0);
    check("snap_d2", cap_seg[2], 8'hA4);
    check("snap_d3", cap_seg[3], 8'hF9);

    // Leading-zero blanking
    show_frame(16'h0050, 4'b0000);
    check("lzb_d3", cap_seg[3], 8'hFF);
    check("lzb_d2", cap_seg[2], 8'hFF);
    check("lzb_d1", cap_seg[1], 8'h92);
    check("lzb_d0", cap_seg[0], 8'hC0);
    check("nolzb_d3", cap_seg2[3], 8'hC0);
    check("nolzb_d2", cap_seg2[2], 8'hC0);

    show_frame(16'h0000, 4'b0000);
    check("zero_d0", cap_seg[0], 8'hC0);
    check("zero_d1", cap_seg[1], 8'hFF);
    check("zero_d3", cap_seg[3], 8'hFF);

    // Invalid code and decimal point
    show_frame(16'h0A00, 4'b0010);
    check("inv_d2", cap_seg[2], 8'hBF);
    check("inv_d3", cap_seg[3], 8'hFF);
    check("dp_d1", cap_seg[1], 8'h40);
    check("dp_d0", cap_seg[0], 8'hC0);

    // Random scoreboard run
    for (int c = 0; c < 200 * FRAME; c++) begin
      if ($urandom_range(7) == 0) begin
        bcd_in = 16'($urandom);
        dp_in  = 4'($urandom);
      end else if ($urandom_range(15) == 0) begin
        bcd_in = 16'($urandom_range(255));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
